alu_accumulator: RTL and testbench
==================================

// Module: alu_accumulator
// PURPOSE
//   Sequential accumulator wrapped around the $alu-inferred adder. Yosys maps the
//   add/sub expression to a FAX1 ripple chain.
//   Accepts one operand plus opcode per valid/ready handshake and updates an internal
//   accumulator. Presents result and flags on a second valid/ready handshake.
//   Registers on both sides of the ripple chain, so the full FAX1 path is one
//   register-to-register timing arc for LunaPnR.
// PARAMETERS
//   WIDTH      8   accumulator/operand width; carry chain length in FAX1 cells
//   CNT_WIDTH  16  width of the saturating completed-operation counter
// PORTS
//   clk        in   1          rising-edge clock
//   rst_n      in   1          asynchronous, active-low reset
//   in_valid   in   1          operand/opcode valid
//   in_ready   out  1          block can accept an operation (state IDLE)
//   in_op      in   2          00 ADD, 01 SUB, 10 LOAD, 11 CLR
//   in_data    in   WIDTH      operand
//   out_valid  out  1          result/flags valid (state DONE)
//   out_ready  in   1          consumer accepts result
//   result     out  WIDTH      accumulator value after the operation
//   carry      out  1          ADD: carry out of MSB; SUB: 1 = no borrow (acc >= operand, unsigned)
//   overflow   out  1          two's-complement signed overflow of ADD/SUB
//   zero       out  1          result == 0
//   op_count   out  CNT_WIDTH  completed output handshakes, saturating at all-ones
// BEHAVIOUR
//   Reset (async, rst_n=0)
//     - acc, result, carry, overflow, zero, op_count = 0; state = IDLE.
//     - in_ready=1 and out_valid=0 immediately.
//     - Reset mid-operation abandons the op; no output is produced.
//   FSM
//     - IDLE -> EXEC on in_valid&&in_ready. in_op and in_data are registered.
//     - EXEC -> DONE unconditionally after 1 cycle. acc and flags update at the EXEC edge.
//     - DONE -> IDLE on out_valid&&out_ready. op_count increments here unless already all-ones.
//   Outputs
//     - in_ready = (state==IDLE); out_valid = (state==DONE). Both decoded from registered state only.
//     - No combinational in->out paths.
//   Timing
//     - Latency: accept at edge E0, out_valid high after E1.
//     - Earliest in_ready after the result handshake at E2.
//     - Minimum 3 cycles per operation.
//   Arithmetic (WIDTH+1-bit sum)
//     - ADD: {carry,result} = acc + opnd.
//     - SUB: {carry,result} = acc + ~opnd + 1, i.e. $alu with BI=1, CI=1.
//     - overflow = (acc[MSB]==b[MSB]) && (result[MSB]!=acc[MSB]), where b = opnd for ADD and ~opnd for SUB.
//     - LOAD: acc = opnd; carry = overflow = 0.
//     - CLR: acc = 0; carry = overflow = 0; zero = 1.
//     - result always equals the new acc. Wrap-around is modulo 2^WIDTH; no saturation on acc.
//   Backpressure
//     - While in DONE with out_ready=0: result, flags and op_count are held stable; out_valid stays 1.
//     - in_valid is ignored (in_ready=0) in EXEC and DONE; upstream must hold its data.
//   Inputs sampled only on the accepting edge; in_data changes after acceptance have no effect.
// TESTING
//   1. LOAD 0x7F, then ADD 0x01 -> result 0x80, carry 0, overflow 1, zero 0.
//   2. LOAD 0xFF, then ADD 0x01 -> result 0x00, carry 1, overflow 0, zero 1.
//   3. LOAD 0x10, then SUB 0x20 -> result 0xF0, carry 0, overflow 0.
//      Then SUB 0xF0 -> result 0x00, carry 1, zero 1.
//   4. out_ready=0 for 5 cycles in DONE with in_valid=1 and new data
//      -> out_valid, result and flags stable; in_ready 0; acc unchanged.
//   5. rst_n low during EXEC -> same cycle: out_valid 0, in_ready 1.
//      After release: result 0, op_count 0.
//   6. CNT_WIDTH=2, 5 completed ops -> op_count 1,2,3,3,3.
//      Handshake timing: in_ready rises exactly 1 cycle after each out handshake.

Source files
------------

// File: rtl/alu_accumulator.sv
// Purpose: add/sub/load/clear accumulator with flags and a saturating completed-op counter.
// Latency: operation accepted at edge E0, result valid after E1, next accept possible after E2 (3 cycles/op).
// Backpressure: holds result/flags/count in DONE until out_ready; in_ready is low outside IDLE.
module alu_accumulator #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_op,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     result,
  output logic                 carry,
  output logic                 overflow,
  output logic                 zero,
  output logic [CNT_WIDTH-1:0] op_count
);

  localparam int MSB = WIDTH - 1;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           op_q, op_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic                 carry_q, carry_d;
  logic                 ovf_q, ovf_d;
  logic                 zero_q, zero_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0]     b_opnd;
  logic                 cin;
  logic [WIDTH:0]       sum;
  logic [WIDTH-1:0]     acc_new;

  // Single adder shared by ADD and SUB: SUB inverts the operand and injects a carry-in.
  always_comb begin
    cin    = (op_q == OP_SUB);
    b_opnd = cin ? ~opnd_q : opnd_q;
    sum    = {1'b0, acc_q} + {1'b0, b_opnd} + {{WIDTH{1'b0}}, cin};
  end

  // Next-state, operand capture, accumulator/flag update and counter saturation.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    cnt_d   = cnt_q;
    acc_new = acc_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d    = in_op;
          opnd_d  = in_data;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_DONE;
        case (op_q)
          OP_ADD, OP_SUB: begin
            acc_new = sum[MSB:0];
            carry_d = sum[WIDTH];
            // Signed overflow: both addends share a sign that the sum does not.
            ovf_d   = (acc_q[MSB] == b_opnd[MSB]) && (sum[MSB] != acc_q[MSB]);
          end
          OP_LOAD: begin
            acc_new = opnd_q;
            carry_d = 1'b0;
            ovf_d   = 1'b0;
          end
          OP_CLR: begin
            acc_new = '0;
            carry_d = 1'b0;
            ovf_d   = 1'b0;
          end
          default: acc_new = acc_q;
        endcase
        acc_d  = acc_new;
        zero_d = ~|acc_new;
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
          if (cnt_q != {CNT_WIDTH{1'b1}}) begin
            cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // All state registers; async reset abandons any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= OP_ADD;
      opnd_q  <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = acc_q;
  assign carry     = carry_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;
  assign op_count  = cnt_q;

endmodule

// File: tb/tb_alu_accumulator.sv
// Purpose: directed checks of the accumulator: arithmetic table, backpressure hold, mid-op reset, counter saturation.
// Latency: expects result valid two cycles after acceptance and in_ready one cycle after the output handshake.
// Backpressure: holds out_ready low in DONE while presenting new input data that must be ignored.
module tb_alu_accumulator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [1:0] in_op;
  logic [7:0] in_data, result;
  logic       carry, overflow, zero;
  logic [15:0] op_count;

  logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [1:0] b_in_op;
  logic [7:0] b_in_data, b_result;
  logic       b_carry, b_overflow, b_zero;
  logic [1:0] b_op_count;

  int total = 0;
  int passed = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  alu_accumulator #(.WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry(carry), .overflow(overflow), .zero(zero), .op_count(op_count)
  );

  alu_accumulator #(.WIDTH(8), .CNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_op(b_in_op), .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .result(b_result), .carry(b_carry), .overflow(b_overflow), .zero(b_zero), .op_count(b_op_count)
  );

  typedef struct {
    logic [1:0] op;
    logic [7:0] data;
    logic [7:0] res;
    logic       c;
    logic       o;
    logic       z;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Full operation on the main instance; called and returns at a falling edge with the DUT idle.
  task automatic do_op(input logic [1:0] op, input logic [7:0] d, input logic [7:0] er,
                       input logic ec, input logic eo, input logic ez);
    int n;
    in_valid = 1'b1; in_op = op; in_data = d;
    n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    chk("accept_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0; in_data = ~d;
    chk("exec_out_valid", out_valid, 0);
    chk("exec_in_ready", in_ready, 0);
    @(negedge clk);
    chk("done_out_valid", out_valid, 1);
    chk("result", result, er);
    chk("carry", carry, ec);
    chk("overflow", overflow, eo);
    chk("zero", zero, ez);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    exp_cnt++;
    chk("post_hs_in_ready", in_ready, 1);
    chk("post_hs_out_valid", out_valid, 0);
    chk("op_count", op_count, exp_cnt);
  endtask

  initial begin
    int n;
    logic [1:0] sat_exp [5];

    vecs[0]  = '{2'b10, 8'h7F, 8'h7F, 1'b0, 1'b0, 1'b0}; // LOAD 7F
    vecs[1]  = '{2'b00, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0}; // ADD 01 -> signed overflow
    vecs[2]  = '{2'b10, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0}; // LOAD FF
    vecs[3]  = '{2'b00, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1}; // ADD 01 -> wrap, carry, zero
    vecs[4]  = '{2'b10, 8'h10, 8'h10, 1'b0, 1'b0, 1'b0}; // LOAD 10
    vecs[5]  = '{2'b01, 8'h20, 8'hF0, 1'b0, 1'b0, 1'b0}; // SUB 20 -> borrow
    vecs[6]  = '{2'b01, 8'hF0, 8'h00, 1'b1, 1'b0, 1'b1}; // SUB F0 -> no borrow, zero
    vecs[7]  = '{2'b10, 8'h80, 8'h80, 1'b0, 1'b0, 1'b0}; // LOAD 80
    vecs[8]  = '{2'b01, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0}; // SUB 01 -> signed overflow
    vecs[9]  = '{2'b00, 8'h80, 8'hFF, 1'b0, 1'b0, 1'b0}; // ADD 80
    vecs[10] = '{2'b11, 8'hA5, 8'h00, 1'b0, 1'b0, 1'b1}; // CLR
    vecs[11] = '{2'b10, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1}; // LOAD 00 -> zero

    sat_exp[0] = 2'd1; sat_exp[1] = 2'd2; sat_exp[2] = 2'd3; sat_exp[3] = 2'd3; sat_exp[4] = 2'd3;

    rst_n = 1'b0;
    in_valid = 1'b0; in_op = 2'b00; in_data = 8'h00; out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_op = 2'b00; b_in_data = 8'h00; b_out_ready = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_result", result, 0);
    chk("rst_carry", carry, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_zero", zero, 0);
    chk("rst_op_count", op_count, 0);

    // Arithmetic table.
    for (int i = 0; i < 12; i++) begin
      do_op(vecs[i].op, vecs[i].data, vecs[i].res, vecs[i].c, vecs[i].o, vecs[i].z);
    end

    // Backpressure: hold in DONE for 5 cycles while offering a different operation.
    in_valid = 1'b1; in_op = 2'b10; in_data = 8'h55;
    n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_op = 2'b00; in_data = 8'h11 + 8'(i);
      chk("hold_out_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_result", result, 8'h55);
      chk("hold_flags", {carry, overflow, zero}, 3'b000);
      chk("hold_op_count", op_count, exp_cnt);
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    exp_cnt++;
    chk("hold_release_count", op_count, exp_cnt);
    do_op(2'b00, 8'h00, 8'h55, 1'b0, 1'b0, 1'b0); // acc must still be 55

    // Reset during EXEC abandons the operation.
    in_valid = 1'b1; in_op = 2'b10; in_data = 8'h33;
    n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    in_valid = 1'b0;
    chk("pre_rst_in_ready", in_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_cnt = 0;
    chk("postrst_result", result, 0);
    chk("postrst_op_count", op_count, 0);
    chk("postrst_out_valid", out_valid, 0);

    // Counter saturation on the 2-bit instance.
    for (int i = 0; i < 5; i++) begin
      b_in_valid = 1'b1; b_in_op = 2'b00; b_in_data = 8'h01;
      n = 0;
      while (!b_in_ready && n < 20) begin @(negedge clk); n++; end
      @(negedge clk);
      b_in_valid = 1'b0;
      n = 0;
      while (!b_out_valid && n < 10) begin @(negedge clk); n++; end
      chk("sat_out_valid", b_out_valid, 1);
      chk("sat_result", b_result, 8'(i + 1));
      b_out_ready = 1'b1;
      @(negedge clk);
      b_out_ready = 1'b0;
      chk("sat_in_ready_after_hs", b_in_ready, 1);
      chk("sat_op_count", b_op_count, sat_exp[i]);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
